key_arpeggiator: RTL and testbench



---
 rtl/key_arpeggiator.sv | 202 ++++++++++++++++++++
 tb/tb_key_arpeggiator.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_arpeggiator.sv
// key_arpeggiator: synchronizes/debounces a pushbutton key bank, optionally latches chords and arpeggiates them (ARP_UPDOWN_EN selects up/down pattern)
module key_arpeggiator #(
    parameter int NKEYS       = 17,
    parameter int DB_TICK     = 120000,
    parameter int STEP_CYCLES = 1200000,
    parameter int GAP_CYCLES  = 120000
) (
    input  logic             hwclk,
    input  logic             reset,
    input  logic [NKEYS-1:0] pb_raw,
    input  logic             hold_en,
    input  logic             arp_en,
    output logic [NKEYS-1:0] keys_out,
    output logic             step_strobe,
    output logic [4:0]       arp_idx,
    output logic             arp_active
);
    localparam int DBW = DB_TICK > 1 ? $clog2(DB_TICK) : 1;
    localparam int TW = STEP_CYCLES > 1 ? $clog2(STEP_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_TICK - 1);
    localparam logic [TW-1:0] PLAY_LAST = TW'(STEP_CYCLES - GAP_CYCLES - 1);
    localparam logic [TW-1:0] STEP_LAST = TW'(STEP_CYCLES - 1);
    localparam logic [NKEYS-1:0] ONE = NKEYS'(1);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    logic [NKEYS-1:0] pb_m_q, pb_s_q;
    logic [1:0] ctl_m_q, ctl_s_q;
    logic hold_s, arp_s;
    logic [DBW-1:0] cnt_q, cnt_d;
    logic tick;
    logic [NKEYS-1:0] h0_q, h1_q, h2_q, db_q, db_d, latch_q, latch_d, src;
    logic press;
    state_t state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [4:0] idx_q, idx_d, lo_idx, up_idx, nxt_idx;
    logic up_found;
    logic [NKEYS-1:0] keys_q, keys_d;
    logic strobe_q, strobe_d;

    assign hold_s = ctl_s_q[0];
    assign arp_s = ctl_s_q[1];

    // two-flop synchronizers for every button and both mode switches
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            pb_m_q <= '0;
            pb_s_q <= '0;
            ctl_m_q <= '0;
            ctl_s_q <= '0;
        end else begin
            pb_m_q <= pb_raw;
            pb_s_q <= pb_m_q;
            ctl_m_q <= {arp_en, hold_en};
            ctl_s_q <= ctl_m_q;
        end
    end

    assign tick = (cnt_q == DB_LAST);
    assign cnt_d = tick ? '0 : cnt_q + DBW'(1);
    // a key changes state only once three consecutive samples agree
    assign db_d = (h0_q & h1_q & h2_q) | (db_q & (h0_q | h1_q | h2_q));

    // debounce tick counter, per-key 3-sample history and debounced vector
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            h0_q <= '0;
            h1_q <= '0;
            h2_q <= '0;
            db_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (tick) begin
                h0_q <= pb_s_q;
                h1_q <= h0_q;
                h2_q <= h1_q;
            end
            db_q <= db_d;
        end
    end

    // a press after all keys were up starts a new chord; otherwise it adds to it
    assign press = |(db_d & ~db_q);
    assign latch_d = !hold_s ? '0 : !press ? latch_q : (db_q == '0) ? db_d : (latch_q | db_d);
    assign src = hold_s ? latch_q : db_q;

    // chord latch register
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) latch_q <= '0;
        else latch_q <= latch_d;
    end

    // priority scans: lowest set key, and lowest set key above the current index
    always_comb begin
        lo_idx = '0;
        up_idx = '0;
        up_found = 1'b0;
        for (int k = NKEYS - 1; k >= 0; k--) begin
            if (src[k]) lo_idx = 5'(k);
            if (src[k] && k > int'(idx_q)) begin
                up_idx = 5'(k);
                up_found = 1'b1;
            end
        end
    end

    // arpeggiator next state; keys_d is the output that belongs with state_d
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d = idx_q;
        strobe_d = 1'b0;
        if (!arp_s || src == '0) begin
            state_d = IDLE;
            timer_d = '0;
        end else if (state_q == IDLE) begin
            state_d = PLAY;
            timer_d = '0;
            idx_d = lo_idx;
            strobe_d = 1'b1;
        end else if (state_q == PLAY) begin
            timer_d = timer_q + TW'(1);
            if (timer_q == PLAY_LAST) state_d = GAP;
        end else if (timer_q == STEP_LAST) begin
            state_d = PLAY;
            timer_d = '0;
            idx_d = nxt_idx;
            strobe_d = 1'b1;
        end else begin
            timer_d = timer_q + TW'(1);
        end
        keys_d = !arp_s ? src : (state_d == PLAY) ? ((ONE << idx_d) & src) : '0;
    end

`ifdef ARP_UPDOWN_EN
    logic dir_q, dir_d, step_dir;
    logic [4:0] dn_idx;
    logic dn_found;

    // highest set key below the current index
    always_comb begin
        dn_idx = '0;
        dn_found = 1'b0;
        for (int k = 0; k < NKEYS; k++) begin
            if (src[k] && k < int'(idx_q)) begin
                dn_idx = 5'(k);
                dn_found = 1'b1;
            end
        end
    end

    // bounce between the outermost keys without repeating them; dir 1 = descending
    always_comb begin
        nxt_idx = lo_idx;
        step_dir = dir_q;
        if (!dir_q) begin
            if (up_found) nxt_idx = up_idx;
            else if (dn_found) begin
                nxt_idx = dn_idx;
                step_dir = 1'b1;
            end
        end else if (dn_found) nxt_idx = dn_idx;
        else if (up_found) begin
            nxt_idx = up_idx;
            step_dir = 1'b0;
        end
    end

    assign dir_d = (state_d == IDLE) ? 1'b0 : (state_q == GAP && strobe_d) ? step_dir : dir_q;

    // direction flag, cleared whenever the arpeggiator idles
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) dir_q <= 1'b0;
        else dir_q <= dir_d;
    end
`else
    assign nxt_idx = up_found ? up_idx : lo_idx;
`endif

    // arpeggiator state and registered outputs
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            timer_q <= '0;
            idx_q <= '0;
            keys_q <= '0;
            strobe_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q <= idx_d;
            keys_q <= keys_d;
            strobe_q <= strobe_d;
        end
    end

    assign keys_out = keys_q;
    assign step_strobe = strobe_q;
    assign arp_idx = idx_q;
    assign arp_active = (state_q != IDLE);
endmodule

// File: tb/tb_key_arpeggiator.sv
// tb_key_arpeggiator: directed self-checking bench for key_arpeggiator (DB_TICK=4, STEP_CYCLES=20, GAP_CYCLES=4)
module tb_key_arpeggiator;
    localparam int NK = 17;
    logic hwclk = 1'b0;
    logic reset = 1'b1;
    logic [NK-1:0] pb_raw = '0;
    logic hold_en = 1'b0;
    logic arp_en = 1'b0;
    logic [NK-1:0] keys_out;
    logic step_strobe;
    logic [4:0] arp_idx;
    logic arp_active;
    int checks = 0;
    int errors = 0;

    key_arpeggiator #(.NKEYS(NK), .DB_TICK(4), .STEP_CYCLES(20), .GAP_CYCLES(4)) dut (
        .hwclk(hwclk),
        .reset(reset),
        .pb_raw(pb_raw),
        .hold_en(hold_en),
        .arp_en(arp_en),
        .keys_out(keys_out),
        .step_strobe(step_strobe),
        .arp_idx(arp_idx),
        .arp_active(arp_active)
    );

    always #5 hwclk = ~hwclk;

    task automatic wait_keys(input logic [NK-1:0] want, input int limit, output int n);
        n = 0;
        while (keys_out !== want && n < limit) begin
            @(negedge hwclk);
            n++;
        end
    endtask

    task automatic wait_strobe(input int limit, output int n);
        n = 0;
        while (step_strobe !== 1'b1 && n < limit) begin
            @(negedge hwclk);
            n++;
        end
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (arp_active !== 1'b0 && n < limit) begin
            @(negedge hwclk);
            n++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge hwclk);
        checks++;
        if ({keys_out, step_strobe, arp_active, arp_idx} !== '0) begin
            errors++;
            $display("FAIL reset_state: got keys=%h strobe=%b active=%b idx=%0d, expected all zero", keys_out, step_strobe, arp_active, arp_idx);
        end
        reset = 1'b0;
        @(negedge hwclk);
        checks++;
        if ({keys_out, step_strobe, arp_active, arp_idx} !== '0) begin
            errors++;
            $display("FAIL first_cycle_after_reset: got keys=%h strobe=%b active=%b idx=%0d, expected all zero", keys_out, step_strobe, arp_active, arp_idx);
        end
    endtask

    task automatic test_debounce;
        int n, bad;
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            pb_raw[3] = ((c / 3) % 2 == 0);
            @(negedge hwclk);
            if (keys_out[3] !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bounce_press: keys_out[3] high in %0d bounce cycles, expected 0", bad);
        end
        pb_raw[3] = 1'b1;
        wait_keys(17'h00008, 30, n);
        checks++;
        if (keys_out !== 17'h00008 || n > 16) begin
            errors++;
            $display("FAIL settle_press: got keys=%h after %0d cycles, expected 00008 within 16", keys_out, n);
        end
        repeat (5) @(negedge hwclk);
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            pb_raw[3] = ((c / 3) % 2 != 0);
            @(negedge hwclk);
            if (keys_out[3] !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bounce_release: keys_out[3] low in %0d bounce cycles, expected 1", bad);
        end
        pb_raw[3] = 1'b0;
        wait_keys('0, 30, n);
        checks++;
        if (keys_out !== '0 || n > 16) begin
            errors++;
            $display("FAIL settle_release: got keys=%h after %0d cycles, expected 0 within 16", keys_out, n);
        end
    endtask

    task automatic test_passthrough;
        int n;
        pb_raw = 17'h10011;
        wait_keys(17'h10011, 30, n);
        checks++;
        if (keys_out !== 17'h10011 || n < 13 || n > 16) begin
            errors++;
            $display("FAIL passthrough_chord: got keys=%h after %0d cycles, expected 10011 after 13..16", keys_out, n);
        end
        pb_raw = '0;
        wait_keys('0, 30, n);
        checks++;
        if (keys_out !== '0) begin
            errors++;
            $display("FAIL passthrough_release: got keys=%h, expected 0", keys_out);
        end
    endtask

    task automatic test_arp_wrap;
        int n, hi, bad;
        logic [4:0] ei [5];
        logic [NK-1:0] ek [5];
        ei = '{5'd2, 5'd5, 5'd9, 5'd2, 5'd5};
        ek = '{17'h00004, 17'h00020, 17'h00200, 17'h00004, 17'h00020};
        pb_raw = 17'h00224;
        wait_keys(17'h00224, 30, n);
        arp_en = 1'b1;
        wait_strobe(10, n);
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (step_strobe !== 1'b1 || arp_idx !== ei[s] || keys_out !== ek[s]) begin
                errors++;
                $display("FAIL arp_note%0d: got strobe=%b idx=%0d keys=%h, expected 1 %0d %h", s, step_strobe, arp_idx, keys_out, ei[s], ek[s]);
            end
            hi = 0;
            bad = 0;
            for (int c = 0; c < 20; c++) begin
                if (keys_out === ek[s]) hi++;
                if ((c > 0 && step_strobe !== 1'b0) || arp_active !== 1'b1) bad++;
                @(negedge hwclk);
            end
            checks++;
            if (hi != 16 || bad != 0) begin
                errors++;
                $display("FAIL arp_shape%0d: got %0d high cycles, %0d bad strobe/active cycles, expected 16 and 0", s, hi, bad);
            end
        end
        checks++;
        if (step_strobe !== 1'b1 || arp_idx !== ei[4]) begin
            errors++;
            $display("FAIL arp_period: got strobe=%b idx=%0d at cycle 20, expected 1 %0d", step_strobe, arp_idx, ei[4]);
        end
        arp_en = 1'b0;
        repeat (3) @(negedge hwclk);
        checks++;
        if (arp_active !== 1'b0 || keys_out !== 17'h00224 || arp_idx !== 5'd5) begin
            errors++;
            $display("FAIL arp_off: got active=%b keys=%h idx=%0d, expected 0 00224 5", arp_active, keys_out, arp_idx);
        end
        pb_raw = '0;
        wait_keys('0, 30, n);
    endtask

    task automatic test_hold;
        int n;
        hold_en = 1'b1;
        repeat (4) @(negedge hwclk);
        pb_raw = 17'h00082;
        wait_keys(17'h00082, 30, n);
        checks++;
        if (keys_out !== 17'h00082) begin
            errors++;
            $display("FAIL hold_first: got keys=%h, expected 00082", keys_out);
        end
        pb_raw = 17'h00482;
        wait_keys(17'h00482, 30, n);
        checks++;
        if (keys_out !== 17'h00482) begin
            errors++;
            $display("FAIL hold_add: got keys=%h, expected 00482", keys_out);
        end
        pb_raw = '0;
        repeat (20) @(negedge hwclk);
        checks++;
        if (keys_out !== 17'h00482) begin
            errors++;
            $display("FAIL hold_keep: got keys=%h after release, expected 00482", keys_out);
        end
        pb_raw = 17'h00008;
        wait_keys(17'h00008, 30, n);
        checks++;
        if (keys_out !== 17'h00008) begin
            errors++;
            $display("FAIL hold_replace: got keys=%h, expected 00008", keys_out);
        end
        pb_raw = '0;
        repeat (20) @(negedge hwclk);
        checks++;
        if (keys_out !== 17'h00008) begin
            errors++;
            $display("FAIL hold_keep2: got keys=%h, expected 00008", keys_out);
        end
        hold_en = 1'b0;
        repeat (4) @(negedge hwclk);
        checks++;
        if (keys_out !== '0) begin
            errors++;
            $display("FAIL hold_clear: got keys=%h, expected 0", keys_out);
        end
    endtask

    task automatic test_key_removed;
        int n, fall, bad;
        pb_raw = 17'h00024;
        wait_keys(17'h00024, 30, n);
        arp_en = 1'b1;
        wait_strobe(10, n);
        checks++;
        if (step_strobe !== 1'b1 || arp_idx !== 5'd2 || keys_out !== 17'h00004) begin
            errors++;
            $display("FAIL removed_first: got strobe=%b idx=%0d keys=%h, expected 1 2 00004", step_strobe, arp_idx, keys_out);
        end
        for (int c = 0; c < 20; c++) begin
            if (c == 19) pb_raw[5] = 1'b0;
            @(negedge hwclk);
        end
        checks++;
        if (step_strobe !== 1'b1 || arp_idx !== 5'd5 || keys_out !== 17'h00020) begin
            errors++;
            $display("FAIL removed_second: got strobe=%b idx=%0d keys=%h, expected 1 5 00020", step_strobe, arp_idx, keys_out);
        end
        fall = -1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (fall < 0 && keys_out[5] !== 1'b1) fall = c;
            if (arp_active !== 1'b1) bad++;
            @(negedge hwclk);
        end
        checks++;
        if (fall < 12 || fall > 15 || bad != 0) begin
            errors++;
            $display("FAIL removed_fall: got fall cycle %0d, %0d inactive cycles, expected 12..15 and 0", fall, bad);
        end
        checks++;
        if (step_strobe !== 1'b1 || arp_idx !== 5'd2 || keys_out !== 17'h00004) begin
            errors++;
            $display("FAIL removed_next: got strobe=%b idx=%0d keys=%h, expected 1 2 00004", step_strobe, arp_idx, keys_out);
        end
        pb_raw = '0;
        wait_idle(30);
        checks++;
        if (arp_active !== 1'b0 || keys_out !== '0) begin
            errors++;
            $display("FAIL removed_idle: got active=%b keys=%h, expected 0 0", arp_active, keys_out);
        end
        arp_en = 1'b0;
        repeat (3) @(negedge hwclk);
    endtask

    task automatic test_updown;
        int n;
        logic [4:0] seq [5];
`ifdef ARP_UPDOWN_EN
        seq = '{5'd0, 5'd2, 5'd5, 5'd2, 5'd0};
`else
        seq = '{5'd0, 5'd2, 5'd5, 5'd0, 5'd2};
`endif
        pb_raw = 17'h00025;
        wait_keys(17'h00025, 30, n);
        arp_en = 1'b1;
        wait_strobe(10, n);
        for (int s = 0; s < 5; s++) begin
            checks++;
            if (step_strobe !== 1'b1 || arp_idx !== seq[s] || keys_out !== (17'd1 << seq[s])) begin
                errors++;
                $display("FAIL pattern%0d: got strobe=%b idx=%0d keys=%h, expected 1 %0d", s, step_strobe, arp_idx, keys_out, seq[s]);
            end
            repeat (20) @(negedge hwclk);
        end
        pb_raw = '0;
        wait_idle(30);
        checks++;
        if (arp_active !== 1'b0 || keys_out !== '0) begin
            errors++;
            $display("FAIL pattern_idle: got active=%b keys=%h, expected 0 0", arp_active, keys_out);
        end
        arp_en = 1'b0;
        repeat (3) @(negedge hwclk);
    endtask

    task automatic test_reset_mid;
        int n, bad;
        pb_raw = 17'h0000a;
        arp_en = 1'b1;
        wait_strobe(40, n);
        repeat (5) @(negedge hwclk);
        checks++;
        if (arp_active !== 1'b1 || keys_out !== 17'h00002 || arp_idx !== 5'd1) begin
            errors++;
            $display("FAIL pre_reset_play: got active=%b keys=%h idx=%0d, expected 1 00002 1", arp_active, keys_out, arp_idx);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({keys_out, step_strobe, arp_active} !== '0) begin
            errors++;
            $display("FAIL reset_async: got keys=%h strobe=%b active=%b, expected 0", keys_out, step_strobe, arp_active);
        end
        @(negedge hwclk);
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge hwclk);
            if (keys_out !== '0 || arp_active !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_redebounce: output active in %0d early cycles, expected 0", bad);
        end
        wait_strobe(30, n);
        checks++;
        if (step_strobe !== 1'b1 || arp_idx !== 5'd1 || keys_out !== 17'h00002) begin
            errors++;
            $display("FAIL reset_restart: got strobe=%b idx=%0d keys=%h, expected 1 1 00002", step_strobe, arp_idx, keys_out);
        end
        pb_raw = '0;
        arp_en = 1'b0;
        repeat (20) @(negedge hwclk);
    endtask

    initial begin
        test_reset;
        test_debounce;
        test_passthrough;
        test_arp_wrap;
        test_hold;
        test_key_removed;
        test_updown;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
